ram_bank_pipe: RTL and testbench

// Parametrised single-port RAM, successor to the fixed 256x32 RAM: configurable width/depth,
// per-byte write enables, valid/ready request handshake, configurable read latency, and

---
 rtl/ram_pkg.sv | 19 +
 rtl/ram_rd_pipe.sv | 64 ++++++
 rtl/ram_bank_pipe.sv | 140 ++++++++++++++
 tb/tb_ram_bank_pipe.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ram_pkg
// Purpose  : Shared types and constants for the ram_bank_pipe scratch RAM.
//            ram_state_e  - controller state (post-reset clear vs. normal run)
//            RAM_MAX_RD_LAT - largest supported read latency in cycles
// Revision : 1.0 - initial release
// ============================================================================
package ram_pkg;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } ram_state_e;

    localparam int RAM_MAX_RD_LAT = 4;

endpackage
`default_nettype wire

// File: rtl/ram_rd_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ram_rd_pipe
// Purpose  : Read-response delay line. Stage 0 registers the array read,
//            stages 1..RD_LAT-1 are pure delay. Data/err only load when the
//            preceding stage is valid, so the last stage holds its data
//            between responses.
// Ports    : clk      in   clock
//            rst      in   synchronous active-high reset (clears valid/data)
//            i_valid  in   read accepted this cycle
//            i_err    in   accepted read was out of range
//            i_data   in   combinational array read data
//            o_valid  out  response valid pulse
//            o_err    out  response error, qualified by o_valid
//            o_data   out  response data, held between responses
// Revision : 1.0 - initial release
// ============================================================================
module ram_rd_pipe #(
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    input  logic              i_err,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic              o_err,
    output logic [DATA_W-1:0] o_data
);

    logic [RD_LAT-1:0] r_vld;
    logic [RD_LAT-1:0] r_err;
    logic [DATA_W-1:0] r_data [RD_LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld <= '0;
            r_err <= '0;
            for (int s = 0; s < RD_LAT; s++) begin
                r_data[s] <= '0;
            end
        end else begin
            r_vld[0] <= i_valid;
            if (i_valid) begin
                r_err[0]  <= i_err;
                r_data[0] <= i_data;
            end
            for (int s = 1; s < RD_LAT; s++) begin
                r_vld[s] <= r_vld[s-1];
                if (r_vld[s-1]) begin
                    r_err[s]  <= r_err[s-1];
                    r_data[s] <= r_data[s-1];
                end
            end
        end
    end

    assign o_valid = r_vld[RD_LAT-1];
    assign o_err   = r_vld[RD_LAT-1] & r_err[RD_LAT-1];
    assign o_data  = r_data[RD_LAT-1];

endmodule
`default_nettype wire

// File: rtl/ram_bank_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ram_bank_pipe
// Purpose  : Parametrised single-port scratch RAM with per-byte write
//            enables, valid/ready request handshake, configurable read
//            latency and a sequential post-reset clear.
// Ports    : clk_i            in   clock
//            rst_i            in   synchronous active-high reset
//            ram_req_valid_i  in   request valid
//            ram_req_ready_o  out  request ready (low during clear)
//            ram_we_i         in   1=write, 0=read
//            ram_be_i         in   byte enables for writes
//            ram_addr_i       in   word address
//            ram_data_i       in   write data
//            ram_rsp_valid_o  out  read response pulse
//            ram_rsp_err_o    out  read addressed beyond DEPTH
//            ram_data_o       out  read data, held between responses
//            ram_init_busy_o  out  post-reset clear in progress
// Revision : 1.0 - initial release
// ============================================================================
module ram_bank_pipe
    import ram_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 256,
    parameter  int RD_LAT = 1,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ram_req_valid_i,
    output logic                  ram_req_ready_o,
    input  logic                  ram_we_i,
    input  logic [DATA_W/8-1:0]   ram_be_i,
    input  logic [ADDR_W-1:0]     ram_addr_i,
    input  logic [DATA_W-1:0]     ram_data_i,
    output logic                  ram_rsp_valid_o,
    output logic                  ram_rsp_err_o,
    output logic [DATA_W-1:0]     ram_data_o,
    output logic                  ram_init_busy_o
);

    localparam int c_nbytes = DATA_W / 8;
    // Out-of-range latency values are clamped so the pipe always has 1..4 stages.
    localparam int c_pipe_lat = (RD_LAT < 1) ? 1 :
                                (RD_LAT > RAM_MAX_RD_LAT) ? RAM_MAX_RD_LAT : RD_LAT;
    localparam logic [ADDR_W:0]   c_depth = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_last  = ADDR_W'(DEPTH - 1);

    ram_state_e        r_state;
    ram_state_e        w_state_nxt;
    logic [ADDR_W-1:0] r_clr_ptr;
    logic [ADDR_W-1:0] w_clr_ptr_nxt;
    logic              w_clr_we;
    logic              w_ready;

    logic [DATA_W-1:0] r_mem [DEPTH];

    logic              w_accept;
    logic              w_addr_ok;
    logic [DATA_W-1:0] w_rd_data;

    // ------------------------------------------------------------------
    // Clear controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_INIT;
            r_clr_ptr <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_ptr <= w_clr_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_ptr_nxt = r_clr_ptr;
        w_clr_we      = 1'b0;
        w_ready       = 1'b0;
        case (r_state)
            ST_INIT: begin
                w_clr_we      = 1'b1;
                w_clr_ptr_nxt = r_clr_ptr + ADDR_W'(1);
                if (r_clr_ptr == c_last) begin
                    w_state_nxt   = ST_RUN;
                    w_clr_ptr_nxt = '0;
                end
            end
            ST_RUN: begin
                w_ready = 1'b1;
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    assign ram_req_ready_o = w_ready;
    assign ram_init_busy_o = (r_state == ST_INIT);

    // ------------------------------------------------------------------
    // Array access
    // ------------------------------------------------------------------
    assign w_accept  = ram_req_valid_i & w_ready;
    // Only reachable with a non-power-of-2 DEPTH.
    assign w_addr_ok = ({1'b0, ram_addr_i} < c_depth);
    assign w_rd_data = w_addr_ok ? r_mem[ram_addr_i] : '0;

    // Array has no reset; the clear sequence zeroes it after every reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (w_clr_we) begin
                r_mem[r_clr_ptr] <= '0;
            end else if (w_accept && ram_we_i && w_addr_ok) begin
                for (int b = 0; b < c_nbytes; b++) begin
                    if (ram_be_i[b]) begin
                        r_mem[ram_addr_i][8*b +: 8] <= ram_data_i[8*b +: 8];
                    end
                end
            end
        end
    end

    ram_rd_pipe #(
        .DATA_W (DATA_W),
        .RD_LAT (c_pipe_lat)
    ) u_rd_pipe (
        .clk     (clk_i),
        .rst     (rst_i),
        .i_valid (w_accept & ~ram_we_i),
        .i_err   (~w_addr_ok),
        .i_data  (w_rd_data),
        .o_valid (ram_rsp_valid_o),
        .o_err   (ram_rsp_err_o),
        .o_data  (ram_data_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_ram_bank_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_bank_pipe
// Purpose  : Self-checking bench for ram_bank_pipe. Instance A is
//            DEPTH=256/RD_LAT=1, instance B is DEPTH=200/RD_LAT=3.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_bank_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic        a_valid, a_we, a_ready, a_rvld, a_rerr, a_busy;
    logic [3:0]  a_be;
    logic [7:0]  a_addr;
    logic [31:0] a_wdata, a_rdata;

    logic        b_valid, b_we, b_ready, b_rvld, b_rerr, b_busy;
    logic [3:0]  b_be;
    logic [7:0]  b_addr;
    logic [31:0] b_wdata, b_rdata;

    int checks = 0;
    int errors = 0;

    ram_bank_pipe #(.DATA_W(32), .DEPTH(256), .RD_LAT(1)) u_a (
        .clk_i(clk), .rst_i(rst),
        .ram_req_valid_i(a_valid), .ram_req_ready_o(a_ready),
        .ram_we_i(a_we), .ram_be_i(a_be), .ram_addr_i(a_addr), .ram_data_i(a_wdata),
        .ram_rsp_valid_o(a_rvld), .ram_rsp_err_o(a_rerr), .ram_data_o(a_rdata),
        .ram_init_busy_o(a_busy)
    );

    ram_bank_pipe #(.DATA_W(32), .DEPTH(200), .RD_LAT(3)) u_b (
        .clk_i(clk), .rst_i(rst),
        .ram_req_valid_i(b_valid), .ram_req_ready_o(b_ready),
        .ram_we_i(b_we), .ram_be_i(b_be), .ram_addr_i(b_addr), .ram_data_i(b_wdata),
        .ram_rsp_valid_o(b_rvld), .ram_rsp_err_o(b_rerr), .ram_data_o(b_rdata),
        .ram_init_busy_o(b_busy)
    );

    typedef struct {
        bit          sel;     // 0 = instance A, 1 = instance B
        bit          we;
        logic [3:0]  be;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] exp_data;
        bit          exp_err;
    } vec_t;

    vec_t vecs [18];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input bit sel, input bit v, input bit we, input logic [3:0] be,
                         input logic [7:0] addr, input logic [31:0] d);
        if (sel) begin
            b_valid = v; b_we = we; b_be = be; b_addr = addr; b_wdata = d;
        end else begin
            a_valid = v; a_we = we; a_be = be; a_addr = addr; a_wdata = d;
        end
    endtask

    task automatic idle(input bit sel);
        drive(sel, 1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    endtask

    task automatic do_write(input bit sel, input logic [7:0] addr, input logic [3:0] be,
                            input logic [31:0] d);
        drive(sel, 1'b1, 1'b1, be, addr, d);
        tick();
        idle(sel);
    endtask

    // Returns the number of extra cycles after the accept edge until the response.
    task automatic do_read(input bit sel, input logic [7:0] addr, output logic [31:0] data,
                           output logic err, output int lat);
        drive(sel, 1'b1, 1'b0, 4'hF, addr, 32'h0);
        tick();
        idle(sel);
        lat = 0;
        while (!(sel ? b_rvld : a_rvld) && lat < 8) begin
            tick();
            lat++;
        end
        data = sel ? b_rdata : a_rdata;
        err  = sel ? b_rerr  : a_rerr;
    endtask

    initial begin
        logic [31:0] rd;
        logic        re;
        int          lat, na, nb, bad, seen;

        vecs[0]  = '{0, 1, 4'hF, 8'd5,   32'hDEADBEEF, 32'h0,        0};
        vecs[1]  = '{0, 1, 4'h1, 8'd5,   32'h000000AA, 32'h0,        0};
        vecs[2]  = '{0, 0, 4'h0, 8'd5,   32'h0,        32'hDEADBEAA, 0};
        vecs[3]  = '{0, 1, 4'hF, 8'd7,   32'h12345678, 32'h0,        0};
        vecs[4]  = '{0, 0, 4'h0, 8'd7,   32'h0,        32'h12345678, 0};
        vecs[5]  = '{0, 1, 4'hA, 8'd9,   32'h11223344, 32'h0,        0};
        vecs[6]  = '{0, 1, 4'h0, 8'd9,   32'hAABBCCDD, 32'h0,        0};
        vecs[7]  = '{0, 0, 4'h0, 8'd9,   32'h0,        32'h11003300, 0};
        vecs[8]  = '{0, 0, 4'h0, 8'd255, 32'h0,        32'h0,        0};
        vecs[9]  = '{0, 1, 4'hF, 8'd255, 32'hCAFEF00D, 32'h0,        0};
        vecs[10] = '{0, 0, 4'h0, 8'd255, 32'h0,        32'hCAFEF00D, 0};
        vecs[11] = '{1, 1, 4'hF, 8'd199, 32'h5A5A5A5A, 32'h0,        0};
        vecs[12] = '{1, 1, 4'hF, 8'd210, 32'hFFFFFFFF, 32'h0,        0};
        vecs[13] = '{1, 0, 4'h0, 8'd210, 32'h0,        32'h0,        1};
        vecs[14] = '{1, 0, 4'h0, 8'd199, 32'h0,        32'h5A5A5A5A, 0};
        vecs[15] = '{1, 1, 4'hC, 8'd199, 32'h12345678, 32'h0,        0};
        vecs[16] = '{1, 0, 4'h0, 8'd199, 32'h0,        32'h12345A5A, 0};
        vecs[17] = '{1, 0, 4'h0, 8'd0,   32'h0,        32'h0,        0};

        rst = 1'b1;
        idle(0);
        idle(1);
        tick(); tick(); tick();

        // Reset state
        check("rst_a_busy",  {31'h0, a_busy},  32'h1);
        check("rst_a_ready", {31'h0, a_ready}, 32'h0);
        check("rst_a_rvld",  {31'h0, a_rvld},  32'h0);
        check("rst_b_rdata", b_rdata,          32'h0);
        rst = 1'b0;

        // Clear duration: busy falls after exactly DEPTH edges
        na = -1; nb = -1;
        for (int n = 1; n <= 300; n++) begin
            tick();
            if (na < 0 && !a_busy) na = n;
            if (nb < 0 && !b_busy) nb = n;
        end
        check("init_cycles_a", na, 32'd256);
        check("init_cycles_b", nb, 32'd200);
        check("ready_a_after_init", {31'h0, a_ready}, 32'h1);

        // Every address of A reads as zero, back-to-back
        bad = 0;
        for (int i = 0; i < 256; i++) begin
            drive(0, 1'b1, 1'b0, 4'h0, 8'(i), 32'h0);
            tick();
            if (a_rvld !== 1'b1 || a_rdata !== 32'h0 || a_rerr !== 1'b0) bad++;
        end
        idle(0);
        tick();
        check("sweep_a_zero_bad", bad, 32'd0);
        check("sweep_a_rvld_drop", {31'h0, a_rvld}, 32'h0);

        // Table-driven vectors
        for (int i = 0; i < 18; i++) begin
            if (vecs[i].we) begin
                do_write(vecs[i].sel, vecs[i].addr, vecs[i].be, vecs[i].data);
            end else begin
                do_read(vecs[i].sel, vecs[i].addr, rd, re, lat);
                check($sformatf("vec%0d_data", i), rd, vecs[i].exp_data);
                check($sformatf("vec%0d_err", i), {31'h0, re}, {31'h0, vecs[i].exp_err});
                check($sformatf("vec%0d_lat", i), lat, vecs[i].sel ? 32'd2 : 32'd0);
            end
        end

        // Back-to-back reads on the latency-3 instance
        do_write(1, 8'd1, 4'hF, 32'h11111111);
        do_write(1, 8'd2, 4'hF, 32'h22222222);
        do_write(1, 8'd3, 4'hF, 32'h33333333);
        for (int k = 0; k < 7; k++) begin
            if (k < 3) drive(1, 1'b1, 1'b0, 4'h0, 8'(k + 1), 32'h0);
            else       idle(1);
            tick();
            check($sformatf("b2b_vld_k%0d", k), {31'h0, b_rvld},
                  (k >= 2 && k <= 4) ? 32'h1 : 32'h0);
            if (k >= 2 && k <= 4)
                check($sformatf("b2b_data_k%0d", k), b_rdata, 32'h11111111 * (k - 1));
        end

        // Reset with two reads in flight
        do_write(1, 8'd50, 4'hF, 32'hABCD0123);
        drive(1, 1'b1, 1'b0, 4'h0, 8'd50, 32'h0);
        tick();
        tick();
        idle(1);
        rst = 1'b1;
        tick();
        check("midrst_rvld", {31'h0, b_rvld}, 32'h0);
        check("midrst_busy", {31'h0, b_busy}, 32'h1);
        check("midrst_rdata", b_rdata, 32'h0);
        rst = 1'b0;
        // Write held during the clear must wait for ready
        drive(1, 1'b1, 1'b1, 4'hF, 8'd60, 32'h0F0F0F0F);
        seen = 0; nb = -1;
        for (int n = 1; n <= 260; n++) begin
            tick();
            if (b_rvld) seen++;
            if (!b_busy) begin
                nb = n;
                break;
            end
        end
        check("midrst_init_cycles", nb, 32'd200);
        check("midrst_no_rsp", seen, 32'd0);
        tick();
        idle(1);
        do_read(1, 8'd50, rd, re, lat);
        check("midrst_cleared", rd, 32'h0);
        do_read(1, 8'd60, rd, re, lat);
        check("held_write", rd, 32'h0F0F0F0F);

        na = 0;
        while (a_busy && na < 300) begin
            tick();
            na++;
        end
        check("a_busy_done", {31'h0, a_busy}, 32'h0);
        do_read(0, 8'd5, rd, re, lat);
        check("a_cleared_after_rst", rd, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
